pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Request/response bundle between a control source and the PC sequencer.
// The master side issues control requests; the slave side (the sequencer)
// returns the ready handshake, the PC slot pulses and the error status.
interface pc_sequencer_if #(
  parameter int PC_W = 9
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [PC_W-1:0] req_target;
  logic            zero_flag;
  logic            pc_inc;
  logic            pc_ref_inc;
  logic            pc_ref_dec;
  logic            pc_set;
  logic [PC_W-1:0] pc_set_value;
  logic [2:0]      depth;
  logic            err;
  logic [1:0]      err_code;

  modport master (
    output req_valid, req_op, req_target, zero_flag,
    input  req_ready, pc_inc, pc_ref_inc, pc_ref_dec, pc_set, pc_set_value,
           depth, err, err_code
  );

  modport slave (
    input  req_valid, req_op, req_target, zero_flag,
    output req_ready, pc_inc, pc_ref_inc, pc_ref_dec, pc_set, pc_set_value,
           depth, err, err_code
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns NEXT/JMP/JZ/CALL/RET requests into
// one-cycle pulses that drive an external multi-slot PC (return stack).
// A CALL is a three-pulse sequence (increment the current slot, push to the
// next slot, load the target). All outputs are registered. Stack overflow,
// underflow and illegal opcodes are swallowed and latched into a sticky
// error flag that records only the first fault.
module pc_sequencer #(
  parameter int PC_W      = 9,
  parameter int MAX_DEPTH = 7
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALL_INC  = 2'd1,
    CALL_PUSH = 2'd2,
    CALL_SET  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  localparam logic [2:0] MAX_D = 3'(MAX_DEPTH);

  state_t          state_r, state_next_s;
  logic            ready_r;
  logic            pc_inc_r, pc_ref_inc_r, pc_ref_dec_r, pc_set_r;
  logic [PC_W-1:0] pc_set_value_r;
  logic [2:0]      depth_r;
  logic            err_r;
  logic [1:0]      err_code_r;
  logic [PC_W-1:0] target_r;

  logic            accept_s;
  logic            inc_s, ref_inc_s, ref_dec_s, set_s;
  logic [PC_W-1:0] set_value_s;
  logic [2:0]      depth_next_s;
  logic [PC_W-1:0] target_next_s;
  logic            err_hit_s;
  logic [1:0]      err_kind_s;

  assign accept_s = bus.req_valid & ready_r;

  // Next-state and next-pulse decode; the final CALL_SET cycle accepts a new
  // request exactly like IDLE so back-to-back requests lose no cycle.
  always_comb begin
    state_next_s  = state_r;
    inc_s         = 1'b0;
    ref_inc_s     = 1'b0;
    ref_dec_s     = 1'b0;
    set_s         = 1'b0;
    set_value_s   = pc_set_value_r;
    depth_next_s  = depth_r;
    target_next_s = target_r;
    err_hit_s     = 1'b0;
    err_kind_s    = 2'b00;
    case (state_r)
      IDLE, CALL_SET: begin
        state_next_s = IDLE;
        if (accept_s) begin
          case (bus.req_op)
            OP_NEXT: inc_s = 1'b1;
            OP_JMP: begin
              set_s       = 1'b1;
              set_value_s = bus.req_target;
            end
            OP_JZ: begin
              if (bus.zero_flag) begin
                set_s       = 1'b1;
                set_value_s = bus.req_target;
              end else begin
                inc_s = 1'b1;
              end
            end
            OP_CALL: begin
              if (depth_r < MAX_D) begin
                inc_s         = 1'b1;
                target_next_s = bus.req_target;
                state_next_s  = CALL_INC;
              end else begin
                err_hit_s  = 1'b1;
                err_kind_s = ERR_OVF;
              end
            end
            OP_RET: begin
              if (depth_r != 3'd0) begin
                ref_dec_s    = 1'b1;
                depth_next_s = depth_r - 3'd1;
              end else begin
                err_hit_s  = 1'b1;
                err_kind_s = ERR_UNF;
              end
            end
            default: begin
              err_hit_s  = 1'b1;
              err_kind_s = ERR_ILL;
            end
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end
      CALL_INC: begin
        ref_inc_s    = 1'b1;
        depth_next_s = depth_r + 3'd1;
        state_next_s = CALL_PUSH;
      end
      CALL_PUSH: begin
        set_s        = 1'b1;
        set_value_s  = target_r;
        state_next_s = CALL_SET;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, pulse, depth and sticky-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      ready_r        <= 1'b0;
      pc_inc_r       <= 1'b0;
      pc_ref_inc_r   <= 1'b0;
      pc_ref_dec_r   <= 1'b0;
      pc_set_r       <= 1'b0;
      pc_set_value_r <= '0;
      depth_r        <= 3'd0;
      err_r          <= 1'b0;
      err_code_r     <= 2'b00;
      target_r       <= '0;
    end else begin
      state_r        <= state_next_s;
      ready_r        <= (state_next_s == IDLE) || (state_next_s == CALL_SET);
      pc_inc_r       <= inc_s;
      pc_ref_inc_r   <= ref_inc_s;
      pc_ref_dec_r   <= ref_dec_s;
      pc_set_r       <= set_s;
      pc_set_value_r <= set_value_s;
      depth_r        <= depth_next_s;
      target_r       <= target_next_s;
      if (err_hit_s && !err_r) begin
        err_r      <= 1'b1;
        err_code_r <= err_kind_s;
      end else begin
        err_r      <= err_r;
        err_code_r <= err_code_r;
      end
    end
  end

  assign bus.req_ready    = ready_r;
  assign bus.pc_inc       = pc_inc_r;
  assign bus.pc_ref_inc   = pc_ref_inc_r;
  assign bus.pc_ref_dec   = pc_ref_dec_r;
  assign bus.pc_set       = pc_set_r;
  assign bus.pc_set_value = pc_set_value_r;
  assign bus.depth        = depth_r;
  assign bus.err          = err_r;
  assign bus.err_code     = err_code_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: single-request vector table, hand-written CALL,
// stack-limit and reset sequences, then random traffic against a reference
// model that schedules expected pulses in a queue.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pc_sequencer_if #(.PC_W(9)) bus ();

  pc_sequencer #(.PC_W(9), .MAX_DEPTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word: ready, inc, ref_inc, ref_dec, set, value (only when set), depth, err, code
  function automatic logic [19:0] pk(input logic rdy, input logic inc, input logic rinc,
                                     input logic rdec, input logic set, input logic [8:0] val,
                                     input logic [2:0] d, input logic e, input logic [1:0] c);
    return {rdy, inc, rinc, rdec, set, (set ? val : 9'h000), d, e, c};
  endfunction

  function automatic logic [19:0] obs();
    return pk(bus.req_ready, bus.pc_inc, bus.pc_ref_inc, bus.pc_ref_dec, bus.pc_set,
              bus.pc_set_value, bus.depth, bus.err, bus.err_code);
  endfunction

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Present one request at the current negedge; returns at the next negedge.
  task automatic req(input logic v, input logic [2:0] op, input logic [8:0] tgt, input logic z);
    bus.req_valid  = v;
    bus.req_op     = op;
    bus.req_target = tgt;
    bus.zero_flag  = z;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("reset_state", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [8:0]  tgt;
    logic        z;
    logic [19:0] exp;
  } row_t;

  typedef struct {
    bit         inc;
    bit         rinc;
    bit         rdec;
    bit         set;
    logic [8:0] val;
    int         dd;
  } act_t;

  row_t tbl[10];
  act_t pend[$];

  int         m_depth;
  bit         m_err;
  logic [1:0] m_code;
  bit         m_ready;

  task automatic m_error(input logic [1:0] c);
    if (!m_err) m_code = c;
    m_err = 1'b1;
  endtask

  initial begin
    logic [19:0] exp;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_target = 9'h000;
    bus.zero_flag  = 1'b0;

    // ---- Vector table: single-cycle operations from reset ----
    tbl[0] = '{1'b1, 3'b000, 9'h000, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00)};
    tbl[1] = '{1'b1, 3'b001, 9'h1A5, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5, 3'd0, 1'b0, 2'b00)};
    tbl[2] = '{1'b1, 3'b010, 9'h040, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h040, 3'd0, 1'b0, 2'b00)};
    tbl[3] = '{1'b1, 3'b010, 9'h040, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00)};
    tbl[4] = '{1'b0, 3'b001, 9'h0FF, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00)};
    tbl[5] = '{1'b1, 3'b001, 9'h1FF, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, 3'd0, 1'b0, 2'b00)};
    tbl[6] = '{1'b1, 3'b001, 9'h000, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 3'd0, 1'b0, 2'b00)};
    tbl[7] = '{1'b1, 3'b100, 9'h000, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b1, 2'b10)};
    tbl[8] = '{1'b1, 3'b110, 9'h033, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b1, 2'b10)};
    tbl[9] = '{1'b1, 3'b000, 9'h000, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b1, 2'b10)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req(tbl[i].v, tbl[i].op, tbl[i].tgt, tbl[i].z);
      chk($sformatf("tbl%0d", i), obs(), tbl[i].exp);
    end

    // ---- CALL 0x100 at depth 0, then back-to-back RET ----
    do_reset();
    req(1'b1, 3'b011, 9'h100, 1'b0);
    chk("call_n1", obs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
    @(negedge clk);
    chk("call_n2", obs(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 3'd1, 1'b0, 2'b00));
    @(negedge clk);
    chk("call_n3", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h100, 3'd1, 1'b0, 2'b00));
    req(1'b1, 3'b100, 9'h000, 1'b0);
    chk("ret_b2b", obs(), pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));

    // ---- Eight CALLs: the eighth overflows; RET still pops ----
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req(1'b1, 3'b011, 9'(i * 16 + 1), 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("call_fill%0d", i), obs(),
          pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'(i * 16 + 1), 3'(i + 1), 1'b0, 2'b00));
    end
    req(1'b1, 3'b011, 9'h0AB, 1'b0);
    chk("call_ovf", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd7, 1'b1, 2'b01));
    req(1'b1, 3'b100, 9'h000, 1'b0);
    chk("ret_after_ovf", obs(), pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h000, 3'd6, 1'b1, 2'b01));

    // ---- Reset asserted during CALL_PUSH ----
    do_reset();
    req(1'b1, 3'b011, 9'h0AA, 1'b0);
    @(negedge clk);
    chk("mid_push", obs(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 3'd1, 1'b0, 2'b00));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
    @(negedge clk);
    chk("mid_rst_hold", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rel", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));
    req(1'b1, 3'b000, 9'h000, 1'b0);
    chk("mid_rst_next", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00));

    // ---- Random traffic against the queue-based reference model ----
    do_reset();
    m_depth = 0;
    m_err   = 1'b0;
    m_code  = 2'b00;
    m_ready = 1'b1;
    pend.delete();
    exp = pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 3'd0, 1'b0, 2'b00);
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       v;
      logic [2:0] op;
      logic [8:0] tgt;
      logic       z;
      int         sel;
      act_t       a;
      chk("rand", obs(), exp);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = 3'b000;
        2:       op = 3'b001;
        3:       op = 3'b010;
        4, 5, 6: op = 3'b011;
        7, 8:    op = 3'b100;
        default: op = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'b000;
      endcase
      tgt = 9'($urandom);
      z   = 1'($urandom);
      bus.req_valid  = v;
      bus.req_op     = op;
      bus.req_target = tgt;
      bus.zero_flag  = z;

      a.inc = 1'b0; a.rinc = 1'b0; a.rdec = 1'b0; a.set = 1'b0; a.val = 9'h000; a.dd = 0;
      if (pend.size() > 0) begin
        a = pend.pop_front();
      end else if (v && m_ready) begin
        case (op)
          3'b000: a.inc = 1'b1;
          3'b001: begin a.set = 1'b1; a.val = tgt; end
          3'b010: begin
            if (z) begin a.set = 1'b1; a.val = tgt; end
            else a.inc = 1'b1;
          end
          3'b011: begin
            if (m_depth < 7) begin
              act_t p;
              a.inc = 1'b1;
              p.inc = 1'b0; p.rinc = 1'b1; p.rdec = 1'b0; p.set = 1'b0; p.val = 9'h000; p.dd = 1;
              pend.push_back(p);
              p.rinc = 1'b0; p.set = 1'b1; p.val = tgt; p.dd = 0;
              pend.push_back(p);
            end else begin
              m_error(2'b01);
            end
          end
          3'b100: begin
            if (m_depth > 0) begin a.rdec = 1'b1; a.dd = -1; end
            else m_error(2'b10);
          end
          default: m_error(2'b11);
        endcase
      end
      m_depth = m_depth + a.dd;
      m_ready = (pend.size() == 0);
      exp = pk(m_ready, a.inc, a.rinc, a.rdec, a.set, a.val, 3'(m_depth), m_err, m_code);
      @(negedge clk);
    end
    chk("rand_final", obs(), exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
